line_arbiter: RTL and testbench

LINE_ARBITER -- requirements
Module: line_arbiter

---
 rtl/line_arbiter_if.sv | 21 ++
 rtl/line_arbiter.sv | 55 +++++
 tb/tb_line_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/line_arbiter_if.sv
// line_arbiter_if: requester, result and register-bank signals of the two-port line arbiter
interface line_arbiter_if #(parameter int DATA_W = 8);
    logic              a_req, a_we, b_req, b_we;
    logic [1:0]        a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, b_gnt, a_done, b_done;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        mem_line_select;
    logic              mem_read_en, mem_write_en;
    logic [DATA_W-1:0] mem_data_in, mem_data_out;
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_data_out,
        output a_gnt, b_gnt, a_done, b_done, rdata,
        output mem_line_select, mem_read_en, mem_write_en, mem_data_in
    );
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_data_out,
        input  a_gnt, b_gnt, a_done, b_done, rdata,
        input  mem_line_select, mem_read_en, mem_write_en, mem_data_in
    );
endinterface

// File: rtl/line_arbiter.sv
// line_arbiter: round-robin arbiter giving requesters A/B single transactions on a 4-line register bank
module line_arbiter #(parameter int DATA_W = 8) (
    input logic clock,
    input logic reset,
    line_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, RD_WAIT, DONE} state_t;
    state_t state, state_nx;
    logic owner, last, pick, any_req, we_q, acc, dn;
    logic [1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    assign any_req = bus.a_req | bus.b_req;
    // owner encoding: 0 = A, 1 = B; on contention the one not served last wins
    assign pick = (bus.a_req & bus.b_req) ? ~last : bus.b_req;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 2'd0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner   <= pick;
                last    <= pick;
                we_q    <= pick ? bus.b_we : bus.a_we;
                addr_q  <= pick ? bus.b_addr : bus.a_addr;
                wdata_q <= pick ? bus.b_wdata : bus.a_wdata;
            end
            if (state == RD_WAIT) rdata_q <= bus.mem_data_out;
        end
    always_comb begin
        state_nx = IDLE;
        acc      = state == ACC;
        dn       = state == DONE;
        case (state)
            IDLE:    state_nx = any_req ? ACC : IDLE;
            ACC:     state_nx = we_q ? DONE : RD_WAIT;
            RD_WAIT: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        bus.a_gnt           = acc & ~owner;
        bus.b_gnt           = acc & owner;
        bus.a_done          = dn & ~owner;
        bus.b_done          = dn & owner;
        bus.mem_line_select = (acc || state == RD_WAIT) ? 4'b0001 << addr_q : 4'b0000;
        bus.mem_write_en    = acc & we_q;
        bus.mem_read_en     = acc & ~we_q;
        bus.mem_data_in     = acc ? wdata_q : '0;
        bus.rdata           = rdata_q;
    end
endmodule

// File: tb/tb_line_arbiter.sv
// tb_line_arbiter: directed vectors plus a bank model and invariant monitor for line_arbiter
module tb_line_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    int n_cmp = 0, n_err = 0;
    logic [7:0] bank [4];
    logic [7:0] shadow [4];
    line_arbiter_if #(.DATA_W(8)) bus ();
    line_arbiter #(.DATA_W(8)) dut (.clock(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int line_of(input logic [3:0] sel);
        return sel[1] ? 1 : sel[2] ? 2 : sel[3] ? 3 : 0;
    endfunction
    // external registered bank: read data appears one cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_write_en) bank[line_of(bus.mem_line_select)] <= bus.mem_data_in;
        if (bus.mem_read_en) bus.mem_data_out <= bank[line_of(bus.mem_line_select)];
    end
    always @(negedge clk) begin
        check("rw_excl", bus.mem_read_en & bus.mem_write_en, 0);
        check("sel_onehot0", $onehot0(bus.mem_line_select), 1);
        check("gnt_excl", bus.a_gnt & bus.b_gnt, 0);
        check("done_excl", bus.a_done & bus.b_done, 0);
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] all_out();
        return {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done, bus.mem_read_en, bus.mem_write_en,
                bus.mem_line_select, bus.rdata, bus.mem_data_in};
    endfunction
    task automatic drive(input logic who, input logic req, input logic we, input logic [1:0] addr,
                         input logic [7:0] data);
        if (who) begin
            bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
        end else begin
            bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
        end
    endtask
    task automatic run_txn(input logic who, input logic we, input logic [1:0] addr,
                           input logic [7:0] data, input logic [7:0] exp);
        logic hit;
        hit = 1'b0;
        drive(who, 1'b1, we, addr, data);
        for (int i = 0; i < 8 && !hit; i++) begin
            tick();
            hit = who ? bus.b_gnt : bus.a_gnt;
        end
        check("txn_gnt", hit, 1);
        drive(who, 1'b0, ~we, ~addr, ~data);
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            tick();
            hit = who ? bus.b_done : bus.a_done;
        end
        check("txn_done", hit, 1);
        if (!we) check("txn_rdata", bus.rdata, exp);
        tick();
    endtask
    initial begin
        for (int i = 0; i < 4; i++) bank[i] = 8'h00;
        bus.mem_data_out = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        tick(); tick();
        check("reset_outputs", all_out(), 0);
        rst = 1'b0;
        // A alone writes line 2
        drive(1'b0, 1'b1, 1'b1, 2'd2, 8'hB3);
        tick();
        check("w_a_gnt", {bus.a_gnt, bus.b_gnt}, 2'b10);
        check("w_sel", bus.mem_line_select, 4'b0100);
        check("w_strobes", {bus.mem_write_en, bus.mem_read_en}, 2'b10);
        check("w_data_in", bus.mem_data_in, 8'hB3);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'hFF);
        tick();
        check("w_a_done", {bus.a_done, bus.b_done, bus.a_gnt}, 3'b100);
        check("w_idle_sel", bus.mem_line_select, 0);
        check("w_rdata_kept", bus.rdata, 8'h00);
        tick();
        check("w_done_pulse", bus.a_done, 0);
        // B alone reads line 2
        drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
        tick();
        check("r_b_gnt", {bus.a_gnt, bus.b_gnt}, 2'b01);
        check("r_strobes", {bus.mem_write_en, bus.mem_read_en}, 2'b01);
        check("r_sel", bus.mem_line_select, 4'b0100);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
        tick();
        check("rw_sel", bus.mem_line_select, 4'b0100);
        check("rw_quiet", {bus.mem_write_en, bus.mem_read_en, bus.b_done}, 0);
        tick();
        check("r_b_done", {bus.a_done, bus.b_done}, 2'b01);
        check("r_rdata", bus.rdata, 8'hB3);
        tick();
        // contention straight after reset alternates A, B, A, B
        rst = 1'b1;
        #1 check("reset_async", all_out(), {16'h0, 8'hB3, 8'h00} & 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h11);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 8'h22);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", {bus.a_gnt, bus.b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            check("rr_done", {bus.a_done, bus.b_done}, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            check("rr_idle", {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}, 0);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        // reset dropped onto a read waiting in RD_WAIT
        run_txn(1'b0, 1'b1, 2'd1, 8'h1E, 8'h00);
        run_txn(1'b0, 1'b0, 2'd3, 8'h00, 8'h22);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        tick();
        check("pre_reset_sel", bus.mem_line_select, 4'b0010);
        #2 rst = 1'b1;
        #1 check("mid_reset_out", all_out(), 0);
        tick();
        check("no_done_reset", {bus.a_done, bus.b_done}, 0);
        tick();
        check("no_done_reset2", {bus.a_done, bus.b_done}, 0);
        rst = 1'b0;
        run_txn(1'b0, 1'b0, 2'd1, 8'h00, 8'h1E);
        // mixed traffic against a per-line shadow
        for (int i = 0; i < 4; i++) begin
            shadow[i] = 8'(8'h40 + i * 8'h13);
            run_txn(1'($urandom_range(0, 1)), 1'b1, 2'(i), shadow[i], 8'h00);
        end
        for (int i = 0; i < 16; i++) begin
            logic who, we;
            logic [1:0] ad;
            logic [7:0] d;
            who = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            ad  = 2'($urandom_range(0, 3));
            d   = 8'($urandom);
            run_txn(who, we, ad, d, shadow[ad]);
            if (we) shadow[ad] = d;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
